// File: rtl/cart_loader.sv
// iNES image loader: parses and validates the 16-byte header, publishes the mapper config,
// then streams the PRG and CHR payloads onto the cart bus ports as single-cycle writes.
module cart_loader #(
  parameter int PRG_BANKS_MAX = 1,
  parameter int CHR_BANKS_MAX = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic [7:0]  data_in,
  input  logic        data_valid_in,
  output logic        ready_out,
  output logic [39:0] cfg_out,
  output logic        cfg_upd_out,
  output logic        prg_nce_out,
  output logic [14:0] prg_a_out,
  output logic        prg_r_nw_out,
  output logic [7:0]  prg_d_out,
  output logic [13:0] chr_a_out,
  output logic        chr_r_nw_out,
  output logic [7:0]  chr_d_out,
  output logic        busy_out,
  output logic        done_out,
  output logic        err_out
);
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_TRAIN, S_PRG, S_CHR, S_DONE, S_ERR
  } state_t;

  localparam logic [7:0] PRG_MAX = 8'(PRG_BANKS_MAX);
  localparam logic [7:0] CHR_MAX = 8'(CHR_BANKS_MAX);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg;
  logic [39:0] shadow_reg;
  logic        beat, magic_bad, hdr_ok, last_beat, trainer;
  logic [7:0]  magic, prg_units, chr_units;
  logic [23:0] cnt_ext, prg_last, chr_last;

  assign beat      = data_valid_in & ready_out;
  assign prg_units = shadow_reg[7:0];
  assign chr_units = shadow_reg[15:8];
  assign trainer   = shadow_reg[18];
  assign cnt_ext   = {8'd0, cnt_reg};
  assign prg_last  = {2'd0, prg_units, 14'd0} - 24'd1;
  assign chr_last  = {3'd0, chr_units, 13'd0} - 24'd1;

  always_comb begin
    case (cnt_reg[1:0])
      2'd0:    magic = 8'h4E;
      2'd1:    magic = 8'h45;
      2'd2:    magic = 8'h53;
      default: magic = 8'h1A;
    endcase
  end

  assign magic_bad = (cnt_reg < 16'd4) && (data_in != magic);
  assign hdr_ok    = (prg_units != 8'd0) && (prg_units <= PRG_MAX) && (chr_units <= CHR_MAX);

  always_comb begin
    last_beat = 1'b0;
    case (state_reg)
      S_HDR:   last_beat = (cnt_reg == 16'd15);
      S_TRAIN: last_beat = (cnt_reg == 16'd511);
      S_PRG:   last_beat = (cnt_ext == prg_last);
      S_CHR:   last_beat = (cnt_ext == chr_last);
      default: last_beat = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE, S_ERR: if (start_in) state_next = S_HDR;
      S_HDR: begin
        if (beat) begin
          if (magic_bad)                state_next = S_ERR;
          else if (last_beat && !hdr_ok) state_next = S_ERR;
          else if (last_beat)           state_next = trainer ? S_TRAIN : S_PRG;
        end
      end
      S_TRAIN: if (beat && last_beat) state_next = S_PRG;
      S_PRG:   if (beat && last_beat) state_next = (chr_units == 8'd0) ? S_DONE : S_CHR;
      S_CHR:   if (beat && last_beat) state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready_out = 1'b0;
    busy_out  = 1'b0;
    done_out  = 1'b0;
    err_out   = 1'b0;
    case (state_reg)
      S_HDR, S_TRAIN, S_PRG, S_CHR: begin
        ready_out = 1'b1;
        busy_out  = 1'b1;
      end
      S_DONE:  done_out = 1'b1;
      S_ERR:   err_out  = 1'b1;
      default: ;
    endcase
  end

  // Beat counter restarts at zero whenever the state changes.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                        cnt_reg <= 16'd0;
    else if (state_next != state_reg)  cnt_reg <= 16'd0;
    else if (beat)                     cnt_reg <= cnt_reg + 16'd1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      shadow_reg  <= 40'd0;
      cfg_out     <= 40'd0;
      cfg_upd_out <= 1'b0;
    end else begin
      cfg_upd_out <= 1'b0;
      if (state_reg == S_HDR && beat) begin
        case (cnt_reg)
          16'd4:   shadow_reg[7:0]   <= data_in;
          16'd5:   shadow_reg[15:8]  <= data_in;
          16'd6:   shadow_reg[23:16] <= data_in;
          16'd7:   shadow_reg[31:24] <= data_in;
          16'd8:   shadow_reg[39:32] <= data_in;
          default: ;
        endcase
        if (last_beat && hdr_ok) begin
          cfg_out     <= shadow_reg;
          cfg_upd_out <= 1'b1;
        end
      end
    end
  end

  // Payload writes land one cycle after the beat and last exactly one cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      prg_nce_out  <= 1'b1;
      prg_r_nw_out <= 1'b1;
      prg_a_out    <= 15'd0;
      prg_d_out    <= 8'd0;
      chr_r_nw_out <= 1'b1;
      chr_a_out    <= 14'd0;
      chr_d_out    <= 8'd0;
    end else begin
      prg_nce_out  <= 1'b1;
      prg_r_nw_out <= 1'b1;
      chr_r_nw_out <= 1'b1;
      if (state_reg == S_PRG && beat) begin
        prg_nce_out  <= 1'b0;
        prg_r_nw_out <= 1'b0;
        prg_a_out    <= cnt_reg[14:0];
        prg_d_out    <= data_in;
      end
      if (state_reg == S_CHR && beat) begin
        chr_r_nw_out <= 1'b0;
        chr_a_out    <= {1'b0, cnt_reg[12:0]};
        chr_d_out    <= data_in;
      end
    end
  end
endmodule

// File: tb/tb_cart_loader.sv
// Scoreboard bench for cart_loader: a header-rule model fills expected cfg/PRG/CHR queues,
// a monitor pops and compares on every cfg pulse and bus write.
module tb_cart_loader;
  localparam int PRG_MAX = 1;
  localparam int CHR_MAX = 1;

  logic        clk_in = 1'b0;
  logic        rst_in, start_in, data_valid_in;
  logic [7:0]  data_in;
  logic        ready_out, cfg_upd_out, prg_nce_out, prg_r_nw_out, chr_r_nw_out;
  logic        busy_out, done_out, err_out;
  logic [39:0] cfg_out;
  logic [14:0] prg_a_out;
  logic [13:0] chr_a_out;
  logic [7:0]  prg_d_out, chr_d_out;

  always #5 clk_in = ~clk_in;

  cart_loader #(.PRG_BANKS_MAX(PRG_MAX), .CHR_BANKS_MAX(CHR_MAX)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .data_in(data_in),
    .data_valid_in(data_valid_in), .ready_out(ready_out), .cfg_out(cfg_out),
    .cfg_upd_out(cfg_upd_out), .prg_nce_out(prg_nce_out), .prg_a_out(prg_a_out),
    .prg_r_nw_out(prg_r_nw_out), .prg_d_out(prg_d_out), .chr_a_out(chr_a_out),
    .chr_r_nw_out(chr_r_nw_out), .chr_d_out(chr_d_out), .busy_out(busy_out),
    .done_out(done_out), .err_out(err_out)
  );

  int n_pass = 0;
  int n_total = 0;
  logic [22:0] prg_q[$];
  logic [21:0] chr_q[$];
  logic [39:0] cfg_q[$];
  bit expect_done = 0;
  logic [39:0] cfg_e;
  logic [22:0] prg_e;
  logic [21:0] chr_e;
  bit wrote;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic fail_extra(input string name, input logic [63:0] act);
    n_total++;
    $display("FAIL %s: got %0h required no event", name, act);
  endtask

  // Monitor: every cfg pulse and bus write must match the head of its queue.
  initial forever begin
    @(negedge clk_in);
    if (!rst_in) begin
      wrote = 0;
      if (cfg_upd_out) begin
        if (cfg_q.size() == 0) fail_extra("cfg_upd", 64'(cfg_out));
        else begin cfg_e = cfg_q.pop_front(); check("cfg_value", 64'(cfg_out), 64'(cfg_e)); end
      end
      if (!prg_nce_out || !prg_r_nw_out) begin
        wrote = 1;
        if (prg_q.size() == 0) fail_extra("prg_write", 64'({prg_a_out, prg_d_out}));
        else begin
          prg_e = prg_q.pop_front();
          check("prg_write", 64'({prg_nce_out, prg_r_nw_out, prg_a_out, prg_d_out}), 64'({2'b00, prg_e}));
        end
      end
      if (!chr_r_nw_out) begin
        wrote = 1;
        if (chr_q.size() == 0) fail_extra("chr_write", 64'({chr_a_out, chr_d_out}));
        else begin
          chr_e = chr_q.pop_front();
          check("chr_write", 64'({chr_r_nw_out, chr_a_out, chr_d_out}), 64'({1'b0, chr_e}));
        end
      end
      if (expect_done && wrote && prg_q.size() == 0 && chr_q.size() == 0) begin
        check("done_with_last_write", 64'({busy_out, done_out}), 64'(2'b01));
        expect_done = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Reference model: derives accepted-byte count, error and all expected writes from the image.
  task automatic model(input logic [7:0] img[$], output int n_exp, output bit exp_err);
    logic [7:0] magic [4];
    logic [7:0] f6;
    int off;
    magic = '{8'h4E, 8'h45, 8'h53, 8'h1A};
    exp_err = 0;
    for (int k = 0; k < 4; k++) begin
      if (img[k] != magic[k]) begin n_exp = k + 1; exp_err = 1; return; end
    end
    if (int'(img[4]) < 1 || int'(img[4]) > PRG_MAX || int'(img[5]) > CHR_MAX) begin
      n_exp = 16; exp_err = 1; return;
    end
    cfg_q.push_back({img[8], img[7], img[6], img[5], img[4]});
    f6 = img[6];
    off = f6[2] ? 16 + 512 : 16;
    for (int n = 0; n < int'(img[4]) * 16384; n++) prg_q.push_back({15'(n), img[off + n]});
    off += int'(img[4]) * 16384;
    for (int n = 0; n < int'(img[5]) * 8192; n++) chr_q.push_back({14'(n), img[off + n]});
    n_exp = off + int'(img[5]) * 8192;
  endtask

  task automatic make_image(input logic [7:0] hdr[16], input int payload, output logic [7:0] img[$]);
    img = {};
    for (int i = 0; i < 16; i++) img.push_back(hdr[i]);
    for (int i = 0; i < payload; i++) img.push_back(8'($urandom));
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_wait, output bit ok);
    data_in = b;
    data_valid_in = 1'b1;
    ok = 0;
    for (int t = 0; t < max_wait && !ok; t++) begin
      @(negedge clk_in);
      if (ready_out) begin @(posedge clk_in); #1; ok = 1; end
    end
    data_valid_in = 1'b0;
  endtask

  task automatic run_image(input logic [7:0] img[$], input bit gaps, input int limit, output int n_acc);
    bit ok;
    n_acc = 0;
    for (int i = 0; i < img.size() && i < limit; i++) begin
      if (gaps) while ($urandom_range(1, 0) == 1) begin @(posedge clk_in); #1; end
      send_byte(img[i], 16, ok);
      if (!ok) break;
      n_acc++;
    end
  endtask

  task automatic pulse_start(input string name);
    start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    check({name, "_start_flags"}, 64'({busy_out, ready_out, done_out, err_out}), 64'(4'b1100));
  endtask

  task automatic run_test(input string name, input logic [7:0] img[$], input bit gaps);
    int n_exp, n_acc;
    bit exp_err, ok;
    model(img, n_exp, exp_err);
    expect_done = !exp_err;
    pulse_start(name);
    run_image(img, gaps, n_exp, n_acc);
    check({name, "_accepted"}, 64'(n_acc), 64'(n_exp));
    if (exp_err) check({name, "_err_next_cycle"}, 64'({err_out, ready_out}), 64'(2'b10));
    if (n_exp < img.size()) begin
      send_byte(img[n_exp], 4, ok);
      check({name, "_extra_rejected"}, 64'(ok), 64'(0));
    end
    repeat (3) @(posedge clk_in);
    #1;
    check({name, "_final_flags"}, 64'({busy_out, ready_out, done_out, err_out}),
          64'({2'b00, !exp_err, exp_err}));
    check({name, "_prg_left"}, 64'(prg_q.size()), 64'(0));
    check({name, "_chr_left"}, 64'(chr_q.size()), 64'(0));
    check({name, "_cfg_left"}, 64'(cfg_q.size()), 64'(0));
    $display("test %s: accepted %0d bytes, err=%0d done=%0d", name, n_acc, err_out, done_out);
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_flags"}, 64'({ready_out, busy_out, done_out, err_out, cfg_upd_out}), 64'(0));
    check({name, "_cfg"}, 64'(cfg_out), 64'(0));
    check({name, "_rnw"}, 64'({prg_nce_out, prg_r_nw_out, chr_r_nw_out}), 64'(3'b111));
    check({name, "_bus"}, 64'({prg_a_out, prg_d_out, chr_a_out, chr_d_out}), 64'(0));
  endtask

  logic [7:0] hdr [16];
  logic [7:0] img_a[$];
  logic [7:0] img_b[$];
  int n_tmp, n_dummy;
  bit e_dummy;

  initial begin
    rst_in = 1'b1; start_in = 1'b0; data_valid_in = 1'b0; data_in = 8'd0;
    @(negedge clk_in);
    check_reset_state("reset");
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    @(posedge clk_in); #1;

    // Valid NROM image, 1 PRG + 1 CHR, back-to-back beats.
    hdr = '{8'h4E, 8'h45, 8'h53, 8'h1A, 8'h01, 8'h01, 8'h01, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    make_image(hdr, 16384 + 8192, img_a);
    run_test("nrom", img_a, 1'b0);
    check("nrom_cfg", 64'(cfg_out), 64'(40'h00_00_01_01_01));

    // Corrupt magic byte 2.
    hdr[2] = 8'h54;
    make_image(hdr, 16, img_a);
    run_test("bad_magic", img_a, 1'b0);

    // Too many PRG banks: error after beat 15, config untouched.
    hdr[2] = 8'h53; hdr[4] = 8'h02;
    make_image(hdr, 16, img_a);
    run_test("prg_limit", img_a, 1'b0);
    check("prg_limit_cfg_kept", 64'(cfg_out), 64'(40'h00_00_01_01_01));

    // Reset in the middle of PRG, then reload a trainer image with random valid gaps.
    hdr[4] = 8'h01; hdr[5] = 8'h00; hdr[6] = 8'h00;
    make_image(hdr, 16384, img_a);
    model(img_a, n_dummy, e_dummy);
    expect_done = 0;
    pulse_start("pre_reset");
    run_image(img_a, 1'b0, 16 + 300, n_tmp);
    check("pre_reset_accepted", 64'(n_tmp), 64'(316));
    rst_in = 1'b1;
    #1;
    prg_q.delete(); chr_q.delete(); cfg_q.delete();
    @(negedge clk_in);
    check_reset_state("mid_reset");
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    @(posedge clk_in); #1;

    hdr[6] = 8'h04;
    for (int i = 7; i < 16; i++) hdr[i] = 8'($urandom);
    make_image(hdr, 512 + 16384, img_b);
    run_test("trainer_gaps", img_b, 1'b1);
    check("trainer_cfg", 64'(cfg_out), 64'({hdr[8], hdr[7], 8'h04, 8'h00, 8'h01}));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
